// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface mips_multicycle_control_if #(
    parameter int RETIRE_W = 16
);
    logic [5:0]          opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_source;
    logic [3:0]          state;
    logic                instr_done;
    logic                illegal_op;
    logic [RETIRE_W-1:0] retired_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, retired_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, retired_count
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback, stalls on mem_ready and traps unsupported opcodes.
module mips_multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_control_if.master  ctrl_if
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        TRAP      = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                done;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = ctrl_if.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (ctrl_if.opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default:      state_d = TRAP;
                endcase
            end
            MEM_ADDR:  state_d = (ctrl_if.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_d = ctrl_if.mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = ctrl_if.mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            TRAP:      state_d = TRAP;
            default:   state_d = FETCH;
        endcase
    end

    // A store retires in the cycle memory accepts it; everything else retires in its final state.
    always_comb begin
        done = 1'b0;
        case (state_q)
            MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: done = 1'b1;
            MEM_WRITE:                           done = ctrl_if.mem_ready;
            default:                             done = 1'b0;
        endcase
    end

    assign retired_d = done ? retired_q + 1'b1 : retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are gated by rst_n so FETCH's mem_read cannot leak out while reset is held.
    always_comb begin
        ctrl_if.pc_write      = 1'b0;
        ctrl_if.pc_write_cond = 1'b0;
        ctrl_if.i_or_d        = 1'b0;
        ctrl_if.mem_read      = 1'b0;
        ctrl_if.mem_write     = 1'b0;
        ctrl_if.ir_write      = 1'b0;
        ctrl_if.mem_to_reg    = 1'b0;
        ctrl_if.reg_dst       = 1'b0;
        ctrl_if.reg_write     = 1'b0;
        ctrl_if.alu_src_a     = 1'b0;
        ctrl_if.alu_src_b     = 2'b00;
        ctrl_if.alu_op        = 2'b00;
        ctrl_if.pc_source     = 2'b00;
        ctrl_if.illegal_op    = 1'b0;
        ctrl_if.instr_done    = 1'b0;
        if (rst_n) begin
            ctrl_if.instr_done = done;
            case (state_q)
                FETCH: begin
                    ctrl_if.mem_read  = 1'b1;
                    ctrl_if.alu_src_b = 2'b01;
                    ctrl_if.ir_write  = ctrl_if.mem_ready;
                    ctrl_if.pc_write  = ctrl_if.mem_ready;
                end
                DECODE: ctrl_if.alu_src_b = 2'b11;
                MEM_ADDR, ADDI_EXEC: begin
                    ctrl_if.alu_src_a = 1'b1;
                    ctrl_if.alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    ctrl_if.mem_read = 1'b1;
                    ctrl_if.i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    ctrl_if.reg_write  = 1'b1;
                    ctrl_if.mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    ctrl_if.mem_write = 1'b1;
                    ctrl_if.i_or_d    = 1'b1;
                end
                EXECUTE: begin
                    ctrl_if.alu_src_a = 1'b1;
                    ctrl_if.alu_op    = 2'b10;
                end
                R_WB: begin
                    ctrl_if.reg_write = 1'b1;
                    ctrl_if.reg_dst   = 1'b1;
                end
                ADDI_WB: ctrl_if.reg_write = 1'b1;
                BRANCH: begin
                    ctrl_if.alu_src_a     = 1'b1;
                    ctrl_if.alu_op        = 2'b01;
                    ctrl_if.pc_write_cond = 1'b1;
                    ctrl_if.pc_source     = 2'b01;
                end
                JUMP: begin
                    ctrl_if.pc_write  = 1'b1;
                    ctrl_if.pc_source = 2'b10;
                end
                TRAP:    ctrl_if.illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    assign ctrl_if.state         = state_q;
    assign ctrl_if.retired_count = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: a small state model pushes the
// expected per-cycle outputs, which are popped and compared against the DUT.
module tb_mips_multicycle_control;

    localparam int RW = 4;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_READ = 4'd3, S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6, S_R_WB = 4'd7,   S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP = 4'd9,    S_ADDI_EXEC = 4'd10, S_ADDI_WB = 4'd11;
    localparam logic [3:0] S_TRAP = 4'd15;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic [3:0]    st;
        logic [16:0]   ctrl;
        logic          done;
        logic [RW-1:0] ret;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;
    exp_t expQ[$];
    logic [3:0]    modelState;
    logic [RW-1:0] modelRet;
    logic [16:0]   dutCtrl;

    mips_multicycle_control_if #(.RETIRE_W(RW)) ifc ();

    mips_multicycle_control #(.RETIRE_W(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dutCtrl = {ifc.pc_write, ifc.pc_write_cond, ifc.i_or_d, ifc.mem_read,
                      ifc.mem_write, ifc.ir_write, ifc.mem_to_reg, ifc.reg_dst,
                      ifc.reg_write, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_op,
                      ifc.pc_source, ifc.illegal_op};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] expCtrl(input logic [3:0] st, input logic mr);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, ill} = '0;
        {asb, aop, psrc} = '0;
        case (st)
            S_FETCH:                 begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:                asb = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin asa = 1; asb = 2'b10; end
            S_MEM_READ:              begin mrd = 1; iod = 1; end
            S_MEM_WB:                begin rwr = 1; m2r = 1; end
            S_MEM_WRITE:             begin mwr = 1; iod = 1; end
            S_EXECUTE:               begin asa = 1; aop = 2'b10; end
            S_R_WB:                  begin rwr = 1; rdst = 1; end
            S_ADDI_WB:               rwr = 1;
            S_BRANCH:                begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            S_JUMP:                  begin pw = 1; psrc = 2'b10; end
            S_TRAP:                  ill = 1;
            default:                 ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, psrc, ill};
    endfunction

    function automatic logic expDone(input logic [3:0] st, input logic mr);
        return (st == S_MEM_WB) || (st == S_R_WB) || (st == S_ADDI_WB) ||
               (st == S_BRANCH) || (st == S_JUMP) || ((st == S_MEM_WRITE) && mr);
    endfunction

    function automatic logic [3:0] modelNext(input logic [3:0] st, input logic [5:0] op, input logic mr);
        case (st)
            S_FETCH:     return mr ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) return S_MEM_ADDR;
                if (op == OP_R)    return S_EXECUTE;
                if (op == OP_BEQ)  return S_BRANCH;
                if (op == OP_J)    return S_JUMP;
                if (op == OP_ADDI) return S_ADDI_EXEC;
                return S_TRAP;
            end
            S_MEM_ADDR:  return (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  return mr ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: return mr ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   return S_R_WB;
            S_ADDI_EXEC: return S_ADDI_WB;
            S_TRAP:      return S_TRAP;
            default:     return S_FETCH;
        endcase
    endfunction

    // Called at a falling edge: drive inputs, predict, sample 1 ns later, then advance the model.
    task automatic applyStimulus(input logic [5:0] op, input logic mr);
        exp_t e;
        exp_t got;
        ifc.opcode    = op;
        ifc.mem_ready = mr;
        e.st   = modelState;
        e.ctrl = expCtrl(modelState, mr);
        e.done = expDone(modelState, mr);
        e.ret  = modelRet;
        expQ.push_back(e);
        #1;
        got = expQ.pop_front();
        checkOutput("state",   32'(ifc.state),         32'(got.st));
        checkOutput("ctrl",    32'(dutCtrl),           32'(got.ctrl));
        checkOutput("done",    32'(ifc.instr_done),    32'(got.done));
        checkOutput("retired", 32'(ifc.retired_count), 32'(got.ret));
        if (e.done) modelRet = modelRet + 1'b1;
        modelState = modelNext(modelState, op, mr);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        ifc.mem_ready = 1'b1;
        ifc.opcode    = 6'd0;
        #1;
        checkOutput("rstState", 32'(ifc.state),         32'(S_FETCH));
        checkOutput("rstCtrl",  32'(dutCtrl),           32'd0);
        checkOutput("rstDone",  32'(ifc.instr_done),    32'd0);
        checkOutput("rstRet",   32'(ifc.retired_count), 32'd0);
        @(negedge clk);
        checkOutput("rstHold",  32'(ifc.state),         32'(S_FETCH));
        checkOutput("rstHoldCtrl", 32'(dutCtrl),        32'd0);
        modelState = S_FETCH;
        modelRet   = '0;
        rst_n      = 1'b1;
    endtask

    task automatic runInstr(input logic [5:0] op, input int fetchStalls, input int memStalls,
                            input int expCycles, input string tag);
        int   cycles = 0;
        int   fs = fetchStalls;
        int   ms = memStalls;
        logic fin = 1'b0;
        logic mr;
        logic [5:0] drv;
        while (!fin && cycles < 40) begin
            mr = 1'b1;
            if (modelState == S_FETCH && fs > 0) begin
                mr = 1'b0;
                fs--;
            end else if ((modelState == S_MEM_READ || modelState == S_MEM_WRITE) && ms > 0) begin
                mr = 1'b0;
                ms--;
            end
            drv = (modelState == S_FETCH) ? 6'($urandom) : op;
            fin = expDone(modelState, mr);
            applyStimulus(drv, mr);
            cycles++;
        end
        checkOutput(tag, 32'(cycles), 32'(expCycles));
    endtask

    initial begin
        logic [RW-1:0] retSnap;
        checkCount = 0;
        errorCount = 0;
        modelState = S_FETCH;
        modelRet   = '0;
        rst_n      = 1'b0;
        doReset();

        runInstr(OP_R,    0, 0, 4, "cyclesR");
        runInstr(OP_LW,   0, 2, 7, "cyclesLwStall");
        runInstr(OP_SW,   1, 1, 6, "cyclesSwStall");
        runInstr(OP_BEQ,  0, 0, 3, "cyclesBeq");
        runInstr(OP_J,    0, 0, 3, "cyclesJ");
        runInstr(OP_ADDI, 0, 0, 4, "cyclesAddi");
        runInstr(OP_LW,   0, 0, 5, "cyclesLw");
        runInstr(OP_SW,   0, 0, 4, "cyclesSw");
        checkOutput("retiredAfterMix", 32'(ifc.retired_count), 32'd8);

        doReset();
        for (int i = 0; i < 16; i++) runInstr(OP_J, 0, 0, 3, "cyclesJwrap");
        checkOutput("retiredWrap", 32'(ifc.retired_count), 32'd0);

        runInstr(OP_R, 0, 0, 4, "cyclesR2");
        retSnap = modelRet;
        applyStimulus(6'($urandom), 1'b1);
        applyStimulus(OP_BAD, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(6'($urandom), 1'($urandom));
        checkOutput("trapState",  32'(ifc.state),         32'(S_TRAP));
        checkOutput("trapRet",    32'(ifc.retired_count), 32'(retSnap));
        checkOutput("trapIllegal", 32'(ifc.illegal_op),   32'd1);
        doReset();

        applyStimulus(6'($urandom), 1'b1);
        applyStimulus(OP_LW, 1'b1);
        applyStimulus(OP_LW, 1'b1);
        applyStimulus(OP_LW, 1'b0);
        applyStimulus(OP_LW, 1'b0);
        checkOutput("stallState", 32'(ifc.state), 32'(S_MEM_READ));
        doReset();
        runInstr(OP_BEQ, 0, 0, 3, "cyclesBeqAfterAbort");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
